// File: rtl/ula_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// ula_74181 / ula_seq_ctrl : nibble-serial wide 74181 ALU sequencer
// Rev 1.0
//------------------------------------------------------------------------------

module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_n,
  output logic [3:0] f,
  output logic       c_n4,
  output logic       a_eq_b
);

  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_sum;

  // Active-high data: c_n / c_n4 are low when a carry is present.
  always_comb begin
    w_x    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    w_y    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    w_sum  = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, ~c_n};
    f      = m ? ~(w_x ^ w_y) : w_sum[3:0];
    c_n4   = ~w_sum[4];
    a_eq_b = (a == b);
  end

endmodule

module ula_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 c_in,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [4*NIBBLES-1:0] f,
  output logic                 c_out,
  output logic                 a_eq_b,
  output logic                 zero,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0]    c_st_idle  = 2'd0;
  localparam logic [1:0]    c_st_run   = 2'd1;
  localparam logic [1:0]    c_st_done  = 2'd2;
  localparam logic [IW-1:0] c_last_idx = IW'(NIBBLES - 1);
  localparam logic [W-1:0]  c_nib_mask = W'(4'hF);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_f;
  logic [W-1:0]  w_f_next;
  logic [3:0]    r_s;
  logic          r_m;
  logic          r_carry;
  logic          r_eq;
  logic [IW-1:0] r_idx;
  logic [IW+1:0] w_shamt;
  logic [3:0]    w_a_nib [NIBBLES];
  logic [3:0]    w_b_nib [NIBBLES];
  logic [3:0]    w_alu_a;
  logic [3:0]    w_alu_b;
  logic [3:0]    w_alu_f;
  logic          w_alu_cn4;
  logic          w_alu_eq;
  logic          w_accept;
  logic          w_last;

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign w_a_nib[gi] = r_a[4*gi +: 4];
    assign w_b_nib[gi] = r_b[4*gi +: 4];
  end

  assign w_accept = (r_state == c_st_idle) && req_valid;
  assign w_last   = (r_idx == c_last_idx);
  assign w_shamt  = {r_idx, 2'b00};
  assign w_alu_a  = w_a_nib[r_idx];
  assign w_alu_b  = w_b_nib[r_idx];

  ula_74181 u_alu (
    .a      (w_alu_a),
    .b      (w_alu_b),
    .s      (r_s),
    .m      (r_m),
    .c_n    (r_carry),
    .f      (w_alu_f),
    .c_n4   (w_alu_cn4),
    .a_eq_b (w_alu_eq)
  );

  // Only the current nibble changes; upper nibbles keep stale data until reached.
  always_comb begin
    w_f_next = (r_f & ~(c_nib_mask << w_shamt)) | (W'(w_alu_f) << w_shamt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (req_valid)  w_state_next = c_st_run;
      c_st_run:  if (w_last)     w_state_next = c_st_done;
      c_st_done: if (resp_ready) w_state_next = c_st_idle;
      default:                   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == c_st_idle);
    resp_valid = (r_state == c_st_done);
    busy       = (r_state != c_st_idle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_eq    <= 1'b0;
      r_f     <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_s     <= s;
      r_m     <= m;
      r_carry <= c_in;
      r_idx   <= '0;
      r_eq    <= 1'b1;
    end else if (r_state == c_st_run) begin
      r_f     <= w_f_next;
      r_carry <= w_alu_cn4;
      r_eq    <= r_eq & w_alu_eq;
      if (!w_last) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign f      = r_f;
  assign c_out  = r_carry & ~r_m;
  assign a_eq_b = r_eq;
  assign zero   = (r_f == '0);

endmodule
`default_nettype wire

// File: doc/ula_seq_ctrl.md
# ula_seq_ctrl

Nibble-serial sequencer that performs wide (4·NIBBLES-bit) 74181-style operations on a single internal `ula_74181` instance. It processes one nibble per clock, least-significant first, and chains the carry between nibbles through a register. The block sits between a requester issuing wide ALU operations and the 4-bit ALU datapath, and uses valid/ready handshakes on both request and response.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4·NIBBLES; legal range 1..16.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `a`, `b`  in  W  operands.
- `s`  in  4  ALU function select, passed unchanged to every nibble.
- `m`  in  1  mode (1 = logic, 0 = arithmetic), passed unchanged to every nibble.
- `c_in`  in  1  carry into nibble 0, at the `ula_74181` carry polarity.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `f`  out  W  result.
- `c_out`  out  1  carry out of the top nibble in arithmetic mode; 0 in logic mode.
- `a_eq_b`  out  1  AND of every nibble's `a_eq_b`.
- `zero`  out  1  `f == 0`.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready`=1.
  - When `req_valid`=1, at the next edge: latch `a`, `b`, `s`, `m`, `c_in`; set carry register = `c_in`, nibble index = 0, eq accumulator = 1; go to RUN.
- **RUN**
  - The ALU is driven combinationally with the latched `a[4i+3:4i]`, `b[4i+3:4i]`, `s`, `m`, and the carry register.
  - At each edge:
    - write ALU F into `f[4i+3:4i]`;
    - carry register ← ALU `c_out`;
    - eq accumulator &= ALU `a_eq_b`;
    - i ← i+1.
  - After the edge that writes nibble NIBBLES-1, go to DONE. The index saturates there and does not wrap.
- **DONE**
  - `resp_valid`=1.
  - `f`, `c_out`, `a_eq_b` and `zero` are stable and held while `resp_ready`=0 (backpressure of unbounded length).
  - When `resp_ready`=1, at the next edge go to IDLE.
- `c_out` output = carry register when latched `m`=0, else 0.
- `zero` is computed from the final `f` register.
- Inputs `a`, `b`, `s`, `m` and `c_in` are ignored outside the IDLE acceptance edge. Changing them mid-operation has no effect.
- `req_valid` in RUN or DONE is not accepted (`req_ready`=0). The requester holds it.
- Upper nibbles of `f` keep the previous operation's values until they are overwritten during RUN. `f` is only guaranteed valid while `resp_valid`=1.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1;
  - `resp_valid`=0;
  - `busy`=0;
  - `f`=0, `c_out`=0, `a_eq_b`=0, `zero`=1;
  - carry, index and eq registers cleared.
- Reset asserted mid-RUN or in DONE aborts the operation immediately (asynchronous reset). No response is produced and the block returns to IDLE.
- Latency: request accepted at edge E0; `resp_valid` rises after edge E(NIBBLES). With the default NIBBLES=4, that is 4 cycles.
- Throughput: one operation per NIBBLES+2 cycles with `resp_ready` held high. Acceptance and response never share an edge.
- `busy`=1 from the E0 edge until the edge that completes the response handshake.
- For NIBBLES=1, RUN lasts exactly one cycle.

## Test plan
- **Reset:** reset mid-RUN (`m`=0, `s`=1001, after 2 nibbles) → next cycle `resp_valid`=0, `busy`=0, `req_ready`=1, `f`=0. Next request completes normally.
- **Logic XOR:** `m`=1, `s`=0110, a=16'h1234, b=16'h00FF → `f`=16'h12CB, `c_out`=0, `zero`=0, `resp_valid` 4 edges after accept.
- **Carry chain:** `m`=0, `s`=1001 (A plus B), `c_in` at the no-carry level, a=16'h00FF, b=16'h0001 → `f`=16'h0100 with carry propagated across nibbles 0→1→2. a=16'hFFFF, b=16'h0001 → `f`=16'h0000, `zero`=1, `c_out` = carry level.
- **Comparison:** `m`=1, `s`=0000, a=b=16'hA5A5 → `a_eq_b`=1. a=16'hA5A4, b=16'hA5A5 → `a_eq_b`=0. a=16'h75A5, b=16'hA5A5 (top nibble differs) → `a_eq_b`=0.
- **Backpressure:** hold `resp_ready`=0 for 10 cycles in DONE, toggling `a`/`b`/`req_valid` → outputs unchanged, `req_ready`=0. Then `resp_ready`=1 → IDLE next edge, and a back-to-back request accepted at the following edge.
- **Parameter sweep:** NIBBLES=1 and 8 with random logic and arithmetic ops → results match a per-nibble `ula_74181` reference model with chained carry. Latency = NIBBLES.
